// File: rtl/calc_arith_sequencer_pkg.sv
// Shared widths, op codes, state encoding and magnitude helpers for the arithmetic sequencer.
package calc_arith_sequencer_pkg;

    localparam int unsigned W     = 25;
    localparam int unsigned RW    = 35;
    localparam int unsigned SCALE = 1000;
    localparam int unsigned SW    = $clog2(SCALE);
    localparam int unsigned PW    = RW + W;
    localparam int unsigned DCW   = $clog2(PW);
    localparam int unsigned MCW   = $clog2(W);

    // Largest positive magnitude representable in the RW-bit result
    localparam logic [PW-1:0] MAG_MAX = PW'((64'd1 << (RW - 1)) - 64'd1);

    typedef enum logic [1:0] {
        OP_PLUS     = 2'd0,
        OP_MINUS    = 2'd1,
        OP_MULTIPLY = 2'd2,
        OP_DIVIDE   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // |v| of an RW-bit signed value, zero-extended to the product width
    function automatic logic [PW-1:0] mag_a(input logic [RW-1:0] v);
        logic [RW-1:0] t;
        t = v[RW-1] ? (~v + RW'(1)) : v;
        return PW'(t);
    endfunction

    // |v| of a W-bit signed value; -2^(W-1) still fits as unsigned
    function automatic logic [W-1:0] mag_b(input logic [W-1:0] v);
        logic [W-1:0] t;
        t = v[W-1] ? (~v + W'(1)) : v;
        return t;
    endfunction

endpackage

// File: rtl/calc_arith_sequencer_if.sv
// Request/response bus between the calculator FSM and the arithmetic sequencer.
interface calc_arith_sequencer_if;
    import calc_arith_sequencer_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [RW-1:0] req_a;
    logic [W-1:0]  req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_result;
    logic          rsp_err;
    logic          busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err, busy
    );

endinterface

// File: rtl/calc_arith_sequencer_div.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// resolved on the start edge so a full divide takes PW edges including start.
module calc_arith_sequencer_div
    import calc_arith_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] dividend,
    input  logic [PW-1:0] divisor,
    output logic          done,
    output logic [PW-1:0] quotient
);

    logic [PW-1:0]  rem;
    logic [PW-1:0]  dvs;
    logic [DCW-1:0] count;
    logic [PW-1:0]  src_r;
    logic [PW-1:0]  src_q;
    logic [PW-1:0]  src_d;
    logic [PW:0]    shifted;
    logic           take;
    logic [PW-1:0]  rem_next;

    // One restoring step on either fresh operands (start) or the running state
    always_comb begin
        src_r    = start ? '0 : rem;
        src_q    = start ? dividend : quotient;
        src_d    = start ? divisor : dvs;
        shifted  = {src_r, src_q[PW-1]};
        take     = (shifted >= {1'b0, src_d});
        rem_next = take ? (shifted[PW-1:0] - src_d) : shifted[PW-1:0];
    end

    // Iteration registers; done pulses after the final quotient bit lands
    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            count    <= '0;
            done     <= 1'b0;
        end else if (start) begin
            rem      <= rem_next;
            dvs      <= divisor;
            quotient <= {src_q[PW-2:0], take};
            count    <= DCW'(PW - 1);
            done     <= 1'b0;
        end else if (count != '0) begin
            rem      <= rem_next;
            quotient <= {src_q[PW-2:0], take};
            count    <= count - DCW'(1);
            done     <= (count == DCW'(1));
        end else begin
            done     <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_arith_sequencer.sv
// Sequences ADD/SUB (single step) and MUL/DIV (shift-add then restoring divide)
// on signed fixed-point operands for the calculator.
module calc_arith_sequencer
    import calc_arith_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    calc_arith_sequencer_if.slave bus
);

    state_e         state;
    logic           neg;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  mc_sh;
    logic [W-1:0]   m_sh;
    logic [W-1:0]   div_by;
    logic [MCW-1:0] cnt;
    logic [MCW-1:0] mul_last;

    op_e            req_op_c;
    logic [PW-1:0]  a_mag_c;
    logic [W-1:0]   b_mag_c;
    logic [W-1:0]   m_in_c;
    logic [RW:0]    a_ext_c;
    logic [RW:0]    b_ext_c;
    logic [RW:0]    sum_c;
    logic [PW-1:0]  prod_c;
    logic           div_start_c;
    logic [RW-1:0]  res_c;
    logic           div_done;
    logic [PW-1:0]  div_q;

    // Operand decode, add/sub, next shift-add partial sum and signed quotient
    always_comb begin
        req_op_c    = op_e'(bus.req_op);
        a_mag_c     = mag_a(bus.req_a);
        b_mag_c     = mag_b(bus.req_b);
        m_in_c      = (req_op_c == OP_MULTIPLY) ? b_mag_c : W'(SCALE);
        a_ext_c     = {bus.req_a[RW-1], bus.req_a};
        b_ext_c     = {{(RW + 1 - W){bus.req_b[W-1]}}, bus.req_b};
        sum_c       = (req_op_c == OP_MINUS) ? (a_ext_c - b_ext_c) : (a_ext_c + b_ext_c);
        prod_c      = acc + (m_sh[0] ? mc_sh : '0);
        div_start_c = (state == ST_MUL) && (cnt == mul_last);
        res_c       = neg ? (~div_q[RW-1:0] + RW'(1)) : div_q[RW-1:0];
    end

    calc_arith_sequencer_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_c),
        .dividend (prod_c),
        .divisor  (PW'(div_by)),
        .done     (div_done),
        .quotient (div_q)
    );

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            neg            <= 1'b0;
            acc            <= '0;
            mc_sh          <= '0;
            m_sh           <= '0;
            div_by         <= '0;
            cnt            <= '0;
            mul_last       <= '0;
            bus.req_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        neg           <= bus.req_a[RW-1] ^ bus.req_b[W-1];
                        bus.busy      <= 1'b1;
                        bus.req_ready <= 1'b0;
                        if (req_op_c == OP_PLUS || req_op_c == OP_MINUS) begin
                            bus.rsp_result <= sum_c[RW-1:0];
                            bus.rsp_err    <= sum_c[RW] ^ sum_c[RW-1];
                            bus.rsp_valid  <= 1'b1;
                            state          <= ST_DONE;
                        end else if (req_op_c == OP_DIVIDE && bus.req_b == '0) begin
                            bus.rsp_result <= '0;
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_valid  <= 1'b1;
                            state          <= ST_DONE;
                        end else begin
                            // Bit 0 of the multiplier is folded into the accept edge
                            acc      <= m_in_c[0] ? a_mag_c : '0;
                            mc_sh    <= a_mag_c << 1;
                            m_sh     <= m_in_c >> 1;
                            cnt      <= MCW'(1);
                            mul_last <= (req_op_c == OP_MULTIPLY) ? MCW'(W - 1) : MCW'(SW - 1);
                            div_by   <= (req_op_c == OP_MULTIPLY) ? W'(SCALE) : b_mag_c;
                            state    <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    // Last partial sum goes straight into the divider
                    if (div_start_c) begin
                        state <= ST_DIV;
                    end else begin
                        acc   <= prod_c;
                        mc_sh <= mc_sh << 1;
                        m_sh  <= m_sh >> 1;
                        cnt   <= cnt + MCW'(1);
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    bus.rsp_result <= res_c;
                    bus.rsp_err    <= (div_q > MAG_MAX);
                    bus.rsp_valid  <= 1'b1;
                    state          <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arith_sequencer.sv
// Randomized and directed bench for calc_arith_sequencer against an integer reference model.
module tb_calc_arith_sequencer;
    import calc_arith_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    calc_arith_sequencer_if bus();

    calc_arith_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic on real-valued fixed point
    task automatic model(input logic [1:0] op, input logic signed [RW-1:0] a,
                         input logic signed [W-1:0] b, output logic [RW-1:0] res,
                         output logic err, output int lat);
        longint la, lb, s, mag, maxv, minv;
        bit ng;
        la   = longint'(a);
        lb   = longint'(b);
        maxv = (longint'(1) <<< (RW - 1)) - 1;
        minv = -(longint'(1) <<< (RW - 1));
        ng   = (la < 0) != (lb < 0);
        mag  = 0;
        if (op == 2'd0 || op == 2'd1) begin
            s   = (op == 2'd0) ? la + lb : la - lb;
            err = (s > maxv) || (s < minv);
            res = RW'(s);
            lat = 1;
        end else if (op == 2'd3 && lb == 0) begin
            res = '0;
            err = 1'b1;
            lat = 1;
        end else begin
            if (op == 2'd2) begin
                mag = ((la < 0) ? -la : la) * ((lb < 0) ? -lb : lb) / longint'(SCALE);
                lat = 86;
            end else begin
                mag = ((la < 0) ? -la : la) * longint'(SCALE) / ((lb < 0) ? -lb : lb);
                lat = 71;
            end
            err = mag > maxv;
            res = RW'(ng ? -mag : mag);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Issue one request, measure latency, check result, hold, then handshake
    task automatic run_op(input string tag, input logic [1:0] op, input logic signed [RW-1:0] a,
                          input logic signed [W-1:0] b, input int hold);
        logic [RW-1:0] er;
        logic          ee;
        int            el;
        int            lat;
        model(op, a, b, er, ee, el);
        @(negedge clk);
        check_eq({tag, "_ready_in"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        // Garbage with valid still high must be ignored while busy
        bus.req_op = 2'($urandom);
        bus.req_a  = {3'($urandom), $urandom};
        bus.req_b  = 25'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check_eq({tag, "_busy"}, 64'(bus.busy), 64'd1);
                check_eq({tag, "_ready_busy"}, 64'(bus.req_ready), 64'd0);
            end
        end while (!bus.rsp_valid && lat < 200);
        bus.req_valid = 1'b0;
        check_eq({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
        if (!bus.rsp_valid) begin
            do_reset();
            return;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(el));
        check_eq({tag, "_result"}, 64'(bus.rsp_result), 64'(er));
        check_eq({tag, "_err"}, 64'(bus.rsp_err), 64'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
            check_eq({tag, "_hold_result"}, 64'(bus.rsp_result), 64'(er));
            check_eq({tag, "_hold_err"}, 64'(bus.rsp_err), 64'(ee));
            check_eq({tag, "_hold_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check_eq({tag, "_post_valid"}, 64'(bus.rsp_valid), 64'd0);
        check_eq({tag, "_post_ready"}, 64'(bus.req_ready), 64'd1);
        check_eq({tag, "_post_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic signed [RW-1:0] ra;
        logic signed [W-1:0]  rb;
        logic [1:0]           rop;
        bit                   seen;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ready", 64'(bus.req_ready), 64'd1);
        check_eq("reset_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("reset_result", 64'(bus.rsp_result), 64'd0);
        check_eq("reset_err", 64'(bus.rsp_err), 64'd0);
        check_eq("reset_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;

        // Stray rsp_ready with nothing pending
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_rsp_ready_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("idle_rsp_ready_ready", 64'(bus.req_ready), 64'd1);
        bus.rsp_ready = 1'b0;

        run_op("add", OP_PLUS, 35'sd1500, 25'sd2250, 0);
        run_op("sub", OP_MINUS, 35'sd1000, 25'sd4000, 0);
        run_op("mul", OP_MULTIPLY, -35'sd2500, 25'sd4000, 0);
        run_op("div", OP_DIVIDE, 35'sd1000, 25'sd3000, 0);
        run_op("div_neg", OP_DIVIDE, -35'sd1000, 25'sd3000, 0);
        run_op("div_tiny", OP_DIVIDE, -35'sd1, 25'sd3000, 0);
        run_op("div_zero", OP_DIVIDE, 35'sd5000, 25'sd0, 0);
        run_op("add_ovf", OP_PLUS, 35'sh3_FFFF_FFFF, 25'sd1, 0);
        run_op("mul_hold", OP_MULTIPLY, 35'sd1500, -25'sd3000, 5);

        // Reset partway through a multiply: no response may appear
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MULTIPLY;
        bus.req_a     = 35'sd7000;
        bus.req_b     = 25'sd9000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_ready", 64'(bus.req_ready), 64'd1);
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("abort_result", 64'(bus.rsp_result), 64'd0);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check_eq("abort_no_rsp", 64'(seen), 64'd0);
        run_op("mul_after_rst", OP_MULTIPLY, 35'sd2000, 25'sd3000, 0);

        // Randomized mix including full-range operands and zero divisors
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ra = {3'($urandom), $urandom};
            else ra = RW'(int'($urandom_range(0, 10000000)) - 5000000);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = 25'($urandom);
                default: rb = W'(int'($urandom_range(0, 200000)) - 100000);
            endcase
            run_op("rand", rop, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
